// File: rtl/s2p_deserializer.sv
// ============================================================================
// s2p_deserializer
// ----------------------------------------------------------------------------
// Serial-to-parallel deserializer. Collects one bit per s_valid/s_ready beat
// into an N-bit shift register and hands each completed word to a one-word
// output register with a p_valid/p_ready handshake. Together the shift
// register and the output register hold up to two complete words, so the
// serial side only stalls once both are full.
//
// Parameters
//   N          word width in bits (N >= 2)
//   LSB_FIRST  1: k-th received bit goes to p_data[k]
//              0: k-th received bit goes to p_data[N-1-k]
//
// Ports
//   clk      in   single clock, everything updates on its rising edge
//   rst      in   synchronous active-high reset
//   s_data   in   serial data bit
//   s_valid  in   s_data is valid this cycle
//   s_ready  out  block accepts a serial bit this cycle (registered)
//   p_data   out  assembled N-bit word
//   p_valid  out  p_data holds a complete word (registered)
//   p_ready  in   downstream takes p_data this cycle
//   bit_cnt  out  bits of the current partial word accepted so far
// ============================================================================
module s2p_deserializer #(
    parameter int N         = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [N-1:0]         p_data,
    output logic                 p_valid,
    input  logic                 p_ready,
    output logic [$clog2(N)-1:0] bit_cnt
);

    localparam int CW = $clog2(N);

    // COLLECT: shift register is filling, serial side open.
    // PENDING: shift register holds a finished word that could not move
    //          into the occupied output register, serial side closed.
    typedef enum logic {
        COLLECT,
        PENDING
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [CW-1:0]   bit_cnt_q;
    logic [CW-1:0]   bit_cnt_next;
    logic [N-1:0]    shift_q;
    logic [N-1:0]    shift_next;
    logic [N-1:0]    word_with_bit;
    logic [N-1:0]    p_data_q;
    logic [N-1:0]    p_data_next;
    logic            p_valid_q;
    logic            p_valid_next;
    logic            s_ready_q;
    logic            s_ready_next;

    logic            s_beat;
    logic            p_beat;
    logic            word_done;
    logic [CW-1:0]   wr_idx;

    // Handshake qualifiers. Both use only registered ready/valid, so no
    // input reaches an output combinationally.
    assign s_beat    = s_valid && s_ready_q;
    assign p_beat    = p_valid_q && p_ready;
    assign word_done = (bit_cnt_q == CW'(N - 1));

    // Bit position of the incoming bit inside the word. MSB-first simply
    // mirrors the counter so the first bit lands in the top position.
    always_comb begin
        if (LSB_FIRST) begin
            wr_idx = bit_cnt_q;
        end else begin
            wr_idx = CW'(N - 1) - bit_cnt_q;
        end
    end

    // Current shift register contents with the incoming bit merged in.
    // On the completing beat this is the full word, which is what lets the
    // output register load it in the same edge without an extra cycle.
    always_comb begin
        word_with_bit         = shift_q;
        word_with_bit[wr_idx] = s_data;
    end

    // Next-state and datapath decisions. A parallel beat empties the
    // output register by default; any load in the same edge overrides that
    // so back-to-back words flow without a bubble.
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt_q;
        shift_next   = shift_q;
        p_data_next  = p_data_q;
        p_valid_next = p_valid_q;

        if (p_beat) begin
            p_valid_next = 1'b0;
        end

        case (state)
            COLLECT: begin
                if (s_beat) begin
                    shift_next = word_with_bit;
                    if (word_done) begin
                        bit_cnt_next = '0;
                        if (!p_valid_q || p_beat) begin
                            p_data_next  = word_with_bit;
                            p_valid_next = 1'b1;
                        end else begin
                            state_next = PENDING;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_q + CW'(1);
                    end
                end
            end

            PENDING: begin
                if (p_beat) begin
                    p_data_next  = shift_q;
                    p_valid_next = 1'b1;
                    state_next   = COLLECT;
                end
            end

            default: begin
                state_next = COLLECT;
            end
        endcase

        s_ready_next = (state_next == COLLECT);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers. s_ready is held low during reset even though the
    // state is COLLECT, so the serial side only opens on the first edge
    // after reset is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
            p_data_q  <= '0;
            p_valid_q <= 1'b0;
            s_ready_q <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_next;
            shift_q   <= shift_next;
            p_data_q  <= p_data_next;
            p_valid_q <= p_valid_next;
            s_ready_q <= s_ready_next;
        end
    end

    assign s_ready = s_ready_q;
    assign p_data  = p_data_q;
    assign p_valid = p_valid_q;
    assign bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_s2p_deserializer.sv
// ============================================================================
// tb_s2p_deserializer
// ----------------------------------------------------------------------------
// Directed bench for s2p_deserializer with N=4. Two instances share every
// input: one LSB-first and one MSB-first, so each scenario checks both bit
// orders. Expected words are written out by hand.
// ============================================================================
module tb_s2p_deserializer;

    logic       clk;
    logic       rst;
    logic       s_data;
    logic       s_valid;
    logic       p_ready;

    logic       s_ready;
    logic [3:0] p_data;
    logic       p_valid;
    logic [1:0] bit_cnt;

    logic       s_ready_m;
    logic [3:0] p_data_m;
    logic       p_valid_m;
    logic [1:0] bit_cnt_m;

    int checkCount;
    int errorCount;

    s2p_deserializer #(.N(4), .LSB_FIRST(1'b1)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .p_data  (p_data),
        .p_valid (p_valid),
        .p_ready (p_ready),
        .bit_cnt (bit_cnt)
    );

    s2p_deserializer #(.N(4), .LSB_FIRST(1'b0)) dut_msb (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready_m),
        .p_data  (p_data_m),
        .p_valid (p_valid_m),
        .p_ready (p_ready),
        .bit_cnt (bit_cnt_m)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then step to just after the next rising
    // edge so outputs are sampled clear of the edge.
    task automatic applyStimulus(input logic vld, input logic dat, input logic prdy);
        s_valid = vld;
        s_data  = dat;
        p_ready = prdy;
        @(posedge clk);
        #1;
    endtask

    // Compare the visible state of both instances against expectations.
    task automatic expectOut(input string tag, input logic srdy, input logic pvld,
                             input logic chkData, input logic [3:0] dLsb,
                             input logic [3:0] dMsb, input logic [1:0] cnt);
        checkOutput({tag, " s_ready"}, 32'(s_ready), 32'(srdy));
        checkOutput({tag, " p_valid"}, 32'(p_valid), 32'(pvld));
        checkOutput({tag, " bit_cnt"}, 32'(bit_cnt), 32'(cnt));
        checkOutput({tag, " msb s_ready"}, 32'(s_ready_m), 32'(srdy));
        checkOutput({tag, " msb p_valid"}, 32'(p_valid_m), 32'(pvld));
        if (chkData) begin
            checkOutput({tag, " p_data"}, 32'(p_data), 32'(dLsb));
            checkOutput({tag, " msb p_data"}, 32'(p_data_m), 32'(dMsb));
        end
    endtask

    initial begin
        logic [3:0] w1;
        logic [3:0] w2;

        checkCount = 0;
        errorCount = 0;
        rst     = 1'b1;
        s_valid = 1'b1;
        s_data  = 1'b1;
        p_ready = 1'b1;

        // Reset held for three edges with s_valid high.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1);
            expectOut($sformatf("reset%0d", i), 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0);
        end
        // First edge out of reset: the bit is offered but s_ready was still low.
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1);
        expectOut("release", 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0);

        // Basic word 1,0,1,1 with p_ready high.
        w1 = 4'b1101;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, w1[k], 1'b1);
            if (k < 3) expectOut($sformatf("basic%0d", k), 1'b1, 1'b0, 1'b0, 4'b0, 4'b0, 2'(k + 1));
            else       expectOut("basic_word", 1'b1, 1'b1, 1'b1, 4'b1101, 4'b1011, 2'd0);
        end
        applyStimulus(1'b0, 1'b0, 1'b1);
        expectOut("basic_drop", 1'b1, 1'b0, 1'b0, 4'b0, 4'b0, 2'd0);

        // Back-to-back words: 0,1,0,0 then 1,1,1,0 with no gap.
        w1 = 4'b0010;
        w2 = 4'b0111;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, (k < 4) ? w1[k] : w2[k - 4], 1'b1);
            if (k == 3)      expectOut("thru_w1", 1'b1, 1'b1, 1'b1, 4'b0010, 4'b0100, 2'd0);
            else if (k == 7) expectOut("thru_w2", 1'b1, 1'b1, 1'b1, 4'b0111, 4'b1110, 2'd0);
            else             expectOut($sformatf("thru%0d", k), 1'b1, 1'b0, 1'b0, 4'b0, 4'b0, 2'((k + 1) % 4));
        end
        applyStimulus(1'b0, 1'b0, 1'b1);
        expectOut("thru_drop", 1'b1, 1'b0, 1'b0, 4'b0, 4'b0, 2'd0);

        // Backpressure: 1,0,1,1 then 0,0,1,1 with p_ready low.
        w1 = 4'b1101;
        w2 = 4'b1100;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, (k < 4) ? w1[k] : w2[k - 4], 1'b0);
            if (k < 3)       expectOut($sformatf("bp%0d", k), 1'b1, 1'b0, 1'b0, 4'b0, 4'b0, 2'(k + 1));
            else if (k < 7)  expectOut($sformatf("bp%0d", k), 1'b1, 1'b1, 1'b1, 4'b1101, 4'b1011, 2'((k + 1) % 4));
            else             expectOut("bp_full", 1'b0, 1'b1, 1'b1, 4'b1101, 4'b1011, 2'd0);
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            expectOut($sformatf("bp_ignore%0d", i), 1'b0, 1'b1, 1'b1, 4'b1101, 4'b1011, 2'd0);
        end
        applyStimulus(1'b0, 1'b0, 1'b1);
        expectOut("bp_second", 1'b1, 1'b1, 1'b1, 4'b1100, 4'b0011, 2'd0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        expectOut("bp_empty", 1'b1, 1'b0, 1'b0, 4'b0, 4'b0, 2'd0);

        // Gapped input 0,1,1,0 with an idle cycle after every bit; the idle
        // cycles drive s_data=1 to make sure it is not picked up.
        w1 = 4'b0110;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, w1[k], 1'b1);
            if (k < 3) expectOut($sformatf("gap%0d", k), 1'b1, 1'b0, 1'b0, 4'b0, 4'b0, 2'(k + 1));
            else       expectOut("gap_word", 1'b1, 1'b1, 1'b1, 4'b0110, 4'b0110, 2'd0);
            applyStimulus(1'b0, 1'b1, 1'b1);
            expectOut($sformatf("gap_idle%0d", k), 1'b1, 1'b0, 1'b0, 4'b0, 4'b0, 2'((k + 1) % 4));
        end

        // Mid-word reset: two bits in, one-cycle reset, then 0,0,1,1.
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        expectOut("mid_partial", 1'b1, 1'b0, 1'b0, 4'b0, 4'b0, 2'd2);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1);
        expectOut("mid_reset", 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1);
        expectOut("mid_release", 1'b1, 1'b0, 1'b0, 4'b0, 4'b0, 2'd0);
        w1 = 4'b1100;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, w1[k], 1'b1);
            if (k < 3) expectOut($sformatf("mid%0d", k), 1'b1, 1'b0, 1'b0, 4'b0, 4'b0, 2'(k + 1));
            else       expectOut("mid_word", 1'b1, 1'b1, 1'b1, 4'b1100, 4'b0011, 2'd0);
        end
        applyStimulus(1'b0, 1'b0, 1'b1);
        expectOut("mid_drop", 1'b1, 1'b0, 1'b0, 4'b0, 4'b0, 2'd0);

        // Reset while a word is pending and the output register is full.
        w1 = 4'b1101;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, w1[k % 4], 1'b0);
        end
        expectOut("pend_full", 1'b0, 1'b1, 1'b1, 4'b1101, 4'b1011, 2'd0);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1);
        expectOut("pend_reset", 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1);
        expectOut("pend_release", 1'b1, 1'b0, 1'b0, 4'b0, 4'b0, 2'd0);
        w1 = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, w1[k], 1'b1);
        end
        expectOut("pend_after", 1'b1, 1'b1, 1'b1, 4'b0001, 4'b1000, 2'd0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        expectOut("pend_drop", 1'b1, 1'b0, 1'b0, 4'b0, 4'b0, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
